// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: STEP_BITS bits per cycle on one shift/add-subtract datapath.
// Define MDU_EARLY_OUT_EN to finish trivial cases (div by zero, overflow, zero multiply, |rs2|>|rs1|) without RUN.
module mdu_iter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_mdu_rs1,
  input  logic [WIDTH-1:0] i_mdu_rs2,
  input  logic [2:0]       i_mdu_op,
  input  logic             i_mdu_valid,
  output logic             o_mdu_ready,
  output logic [WIDTH-1:0] o_mdu_rd,
  output logic             o_mdu_busy
);

  localparam int unsigned N  = WIDTH / STEP_BITS;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  opd_q;
  logic [WIDTH-1:0]  rs1_q;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_step;
  logic [WIDTH:0]    step_r;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, dz_q, ovf_q;

  logic              is_div_c, s1_c, s2_c, neg1_c, neg2_c, sign_c, dz_c, ovf_c;
  logic [WIDTH-1:0]  mag1_c, mag2_c;
  logic [AW-1:0]     prod_c;
  logic [WIDTH-1:0]  quot_c, remv_c, result_c;
  logic              early_hit_c;
  logic [WIDTH-1:0]  early_rd_c;

  // Operand decode: signedness, magnitudes, result sign and special cases
  assign is_div_c = i_mdu_op[2];
  assign s1_c     = is_div_c ? ~i_mdu_op[0] : (i_mdu_op[1:0] != 2'b11);
  assign s2_c     = is_div_c ? ~i_mdu_op[0] : ~i_mdu_op[1];
  assign neg1_c   = s1_c & i_mdu_rs1[WIDTH-1];
  assign neg2_c   = s2_c & i_mdu_rs2[WIDTH-1];
  assign mag1_c   = neg1_c ? -i_mdu_rs1 : i_mdu_rs1;
  assign mag2_c   = neg2_c ? -i_mdu_rs2 : i_mdu_rs2;
  assign sign_c   = (is_div_c && i_mdu_op[1]) ? neg1_c : (neg1_c ^ neg2_c);
  assign dz_c     = is_div_c && (i_mdu_rs2 == '0);
  assign ovf_c    = is_div_c && !i_mdu_op[0] && (i_mdu_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_mdu_rs2);

`ifdef MDU_EARLY_OUT_EN
  always_comb begin
    early_hit_c = 1'b0;
    early_rd_c  = '0;
    if (is_div_c) begin
      if (dz_c) begin
        early_hit_c = 1'b1;
        early_rd_c  = i_mdu_op[1] ? i_mdu_rs1 : '1;
      end else if (ovf_c) begin
        early_hit_c = 1'b1;
        early_rd_c  = i_mdu_op[1] ? '0 : i_mdu_rs1;
      end else if (mag2_c > mag1_c) begin
        early_hit_c = 1'b1;
        early_rd_c  = i_mdu_op[1] ? i_mdu_rs1 : '0;
      end
    end else if ((i_mdu_rs1 == '0) || (i_mdu_rs2 == '0)) begin
      early_hit_c = 1'b1;
    end
  end
`else
  assign early_hit_c = 1'b0;
  assign early_rd_c  = '0;
`endif

  // One RUN cycle: STEP_BITS shift-add (multiply) or restoring (divide) sub-steps
  always_comb begin
    acc_step = acc_q;
    step_r   = '0;
    for (int i = 0; i < int'(STEP_BITS); i++) begin
      if (op_q[2]) begin
        step_r = {acc_step[AW-1:WIDTH], acc_step[WIDTH-1]};
        acc_step[WIDTH-1:0] = {acc_step[WIDTH-2:0], 1'b0};
        if (step_r >= {1'b0, opd_q}) begin
          step_r      = step_r - {1'b0, opd_q};
          acc_step[0] = 1'b1;
        end
        acc_step[AW-1:WIDTH] = step_r[WIDTH-1:0];
      end else begin
        step_r   = {1'b0, acc_step[AW-1:WIDTH]} + (acc_step[0] ? {1'b0, opd_q} : '0);
        acc_step = {step_r, acc_step[WIDTH-1:1]};
      end
    end
  end

  // Sign fix and result select on the final RUN edge
  assign prod_c = neg_q ? -acc_step : acc_step;
  assign quot_c = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign remv_c = neg_q ? -acc_step[AW-1:WIDTH] : acc_step[AW-1:WIDTH];

  always_comb begin
    result_c = '0;
    case (op_q)
      3'b000:                 result_c = prod_c[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_c = prod_c[AW-1:WIDTH];
      3'b100, 3'b101:         result_c = dz_q ? '1 : (ovf_q ? rs1_q : quot_c);
      default:                result_c = dz_q ? rs1_q : (ovf_q ? '0 : remv_c);
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_mdu_valid) state_d = early_hit_c ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mdu_ready <= 1'b0;
      o_mdu_busy  <= 1'b0;
      o_mdu_rd    <= '0;
      op_q        <= '0;
      opd_q       <= '0;
      rs1_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      o_mdu_ready <= (state_d == DONE);
      o_mdu_busy  <= (state_d != IDLE);
      if ((state_q == IDLE) && i_mdu_valid) begin
        op_q  <= i_mdu_op;
        rs1_q <= i_mdu_rs1;
        neg_q <= sign_c;
        dz_q  <= dz_c;
        ovf_q <= ovf_c;
        cnt_q <= CW'(N - 1);
        opd_q <= is_div_c ? mag2_c : mag1_c;
        acc_q <= {{WIDTH{1'b0}}, (is_div_c ? mag1_c : mag2_c)};
        if (early_hit_c) o_mdu_rd <= early_rd_c;
      end else if (state_q == RUN) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == '0) o_mdu_rd <= result_c;
      end
    end
  end

endmodule
